// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns a valid/ready command port into one
// AXI4-Lite read or write and hands back the response on a valid/ready port.
module axi_lite_cmd_master #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
    input  logic [STROBE_WIDTH-1:0] i_cmd_wstrb,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [1:0]              o_rsp_resp,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_awvalid,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    input  logic                    i_awready,
    output logic                    o_wvalid,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [STROBE_WIDTH-1:0] o_wstrb,
    input  logic                    i_wready,
    input  logic                    i_bvalid,
    input  logic [1:0]              i_bresp,
    output logic                    o_bready,
    output logic                    o_arvalid,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    input  logic                    i_arready,
    input  logic                    i_rvalid,
    input  logic [1:0]              i_rresp,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    o_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t state;
    state_t state_next;
    logic   run;
    logic   aw_done;
    logic   w_done;
    logic   cmd_fire;
    logic   b_fire;
    logic   r_fire;

    assign cmd_fire = i_cmd_valid && o_cmd_ready;
    assign b_fire   = (state == WR_RESP) && i_bvalid;
    assign r_fire   = (state == RD_DATA) && i_rvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // run keeps cmd_ready low while reset is held and for the edge that releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (run && i_cmd_valid) begin
                    state_next = i_cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if ((aw_done || i_awready) && (w_done || i_wready)) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (i_bvalid) begin
                    state_next = RSP;
                end
            end
            RD_REQ: begin
                if (i_arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (i_rvalid) begin
                    state_next = RSP;
                end
            end
            RSP: begin
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_cmd_ready = 1'b0;
        o_awvalid   = 1'b0;
        o_wvalid    = 1'b0;
        o_bready    = 1'b0;
        o_arvalid   = 1'b0;
        o_rready    = 1'b0;
        o_rsp_valid = 1'b0;
        case (state)
            IDLE:    o_cmd_ready = run;
            WR_REQ: begin
                o_awvalid = !aw_done;
                o_wvalid  = !w_done;
            end
            WR_RESP: o_bready    = 1'b1;
            RD_REQ:  o_arvalid   = 1'b1;
            RD_DATA: o_rready    = 1'b1;
            RSP:     o_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // AW and W complete independently; each flag retires its own valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state != WR_REQ) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (i_awready) begin
                aw_done <= 1'b1;
            end
            if (i_wready) begin
                w_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_awaddr <= '0;
            o_araddr <= '0;
            o_wdata  <= '0;
            o_wstrb  <= '0;
        end else if (cmd_fire) begin
            o_awaddr <= i_cmd_addr;
            o_araddr <= i_cmd_addr;
            o_wdata  <= i_cmd_wdata;
            o_wstrb  <= i_cmd_wstrb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rsp_resp  <= 2'b00;
            o_rsp_rdata <= '0;
        end else if (b_fire) begin
            o_rsp_resp  <= i_bresp;
            o_rsp_rdata <= '0;
        end else if (r_fire) begin
            o_rsp_resp  <= i_rresp;
            o_rsp_rdata <= i_rdata;
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Randomized bench for axi_lite_cmd_master: a memory-backed AXI-Lite slave with
// optional random waits, and a scoreboard fed by a word-level reference memory.
module tb_axi_lite_cmd_master;

    logic        clk;
    logic        rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_write;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_wdata;
    logic [3:0]  i_cmd_wstrb;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [1:0]  o_rsp_resp;
    logic [31:0] o_rsp_rdata;
    logic        o_awvalid;
    logic [31:0] o_awaddr;
    logic        i_awready;
    logic        o_wvalid;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        i_wready;
    logic        i_bvalid;
    logic [1:0]  i_bresp;
    logic        o_bready;
    logic        o_arvalid;
    logic [31:0] o_araddr;
    logic        i_arready;
    logic        i_rvalid;
    logic [1:0]  i_rresp;
    logic [31:0] i_rdata;
    logic        o_rready;

    axi_lite_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STROBE_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_resp(o_rsp_resp),
        .o_rsp_rdata(o_rsp_rdata),
        .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .i_awready(i_awready),
        .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .i_wready(i_wready),
        .i_bvalid(i_bvalid), .i_bresp(i_bresp), .o_bready(o_bready),
        .o_arvalid(o_arvalid), .o_araddr(o_araddr), .i_arready(i_arready),
        .i_rvalid(i_rvalid), .i_rresp(i_rresp), .i_rdata(i_rdata), .o_rready(o_rready)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // slave knobs
    logic rnd = 1'b0;
    logic ar_block = 1'b0;
    int   w_hold = 0;
    int   rsp_hold = 0;
    int   w_wait = 0;

    // slave state and handshake bookkeeping
    logic [31:0] smem [16];
    logic [31:0] rmem [16];
    logic [33:0] exp_q [$];
    logic        aw_got, w_got, ar_got;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic        p_aw, p_w, p_b, p_ar, p_r, p_rsp;
    logic [31:0] c_awaddr, c_wdata, c_araddr;
    logic [3:0]  c_wstrb;
    logic        pv_aw, pv_w, pv_ar, pv_rsp;
    logic [31:0] pv_awaddr, pv_wdata, pv_araddr, pv_rdata;
    logic [3:0]  pv_wstrb;
    logic [1:0]  pv_resp;
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_rsp = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] resp_for(input logic [31:0] a);
        case (a[7:6])
            2'b10:   return 2'b10;
            2'b11:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Slave model: retires last edge's handshakes, drives new inputs, predicts next edge.
    always @(negedge clk) begin
        if (rst) begin
            aw_got = 0; w_got = 0; ar_got = 0; w_wait = 0;
            p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0; p_rsp = 0;
            pv_aw = 0; pv_w = 0; pv_ar = 0; pv_rsp = 0;
            i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
            i_arready = 0; i_rvalid = 0; i_rresp = 0; i_rdata = 0; i_rsp_ready = 0;
        end else begin
            if (pv_aw && !p_aw) begin
                check("awvalid_held", 32'(o_awvalid), 32'd1);
                check("awaddr_stable", o_awaddr, pv_awaddr);
            end
            if (pv_w && !p_w) begin
                check("wvalid_held", 32'(o_wvalid), 32'd1);
                check("wdata_stable", o_wdata, pv_wdata);
                check("wstrb_stable", 32'(o_wstrb), 32'(pv_wstrb));
            end
            if (pv_ar && !p_ar) begin
                check("arvalid_held", 32'(o_arvalid), 32'd1);
                check("araddr_stable", o_araddr, pv_araddr);
            end
            if (pv_rsp && !p_rsp) begin
                check("rsp_valid_held", 32'(o_rsp_valid), 32'd1);
                check("rsp_resp_stable", 32'(o_rsp_resp), 32'(pv_resp));
                check("rsp_rdata_stable", o_rsp_rdata, pv_rdata);
            end
            if (p_aw) begin aw_got = 1; s_awaddr = c_awaddr; n_aw++; end
            if (p_w) begin w_got = 1; s_wdata = c_wdata; s_wstrb = c_wstrb; n_w++; w_wait = 0; end
            if (p_b) begin i_bvalid = 0; aw_got = 0; w_got = 0; n_b++; end
            if (p_ar) begin ar_got = 1; s_araddr = c_araddr; n_ar++; end
            if (p_r) begin i_rvalid = 0; ar_got = 0; n_r++; end
            if (p_rsp) n_rsp++;

            if (aw_got && w_got && !i_bvalid && (!rnd || rbit())) begin
                smem[s_awaddr[5:2]] = merge(smem[s_awaddr[5:2]], s_wdata, s_wstrb);
                i_bresp  = resp_for(s_awaddr);
                i_bvalid = 1;
            end
            if (ar_got && !i_rvalid && (!rnd || rbit())) begin
                i_rdata  = smem[s_araddr[5:2]];
                i_rresp  = resp_for(s_araddr);
                i_rvalid = 1;
            end
            i_awready = rnd ? rbit() : 1'b1;
            if (o_wvalid && w_wait < w_hold) begin
                i_wready = 0;
                w_wait++;
            end else begin
                i_wready = rnd ? rbit() : 1'b1;
            end
            i_arready = ar_block ? 1'b0 : (rnd ? rbit() : 1'b1);
            if (o_rsp_valid && rsp_hold > 0) begin
                i_rsp_ready = 0;
                rsp_hold--;
            end else begin
                i_rsp_ready = rnd ? rbit() : 1'b1;
            end

            p_aw = o_awvalid && i_awready;  c_awaddr = o_awaddr;
            p_w  = o_wvalid && i_wready;    c_wdata = o_wdata; c_wstrb = o_wstrb;
            p_b  = i_bvalid && o_bready;
            p_ar = o_arvalid && i_arready;  c_araddr = o_araddr;
            p_r  = i_rvalid && o_rready;
            p_rsp = o_rsp_valid && i_rsp_ready;
            if (p_rsp) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    check("rsp_resp", 32'(o_rsp_resp), 32'(e[33:32]));
                    check("rsp_rdata", o_rsp_rdata, e[31:0]);
                end
            end
            pv_aw = o_awvalid; pv_awaddr = o_awaddr;
            pv_w = o_wvalid; pv_wdata = o_wdata; pv_wstrb = o_wstrb;
            pv_ar = o_arvalid; pv_araddr = o_araddr;
            pv_rsp = o_rsp_valid; pv_resp = o_rsp_resp; pv_rdata = o_rsp_rdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        logic [1:0] r;
        r = resp_for(a);
        i_cmd_valid = 1; i_cmd_write = w; i_cmd_addr = a; i_cmd_wdata = d; i_cmd_wstrb = s;
        if (w) begin
            rmem[a[5:2]] = merge(rmem[a[5:2]], d, s);
            exp_q.push_back({r, 32'h0});
        end else begin
            exp_q.push_back({r, rmem[a[5:2]]});
        end
    endtask

    task automatic wait_accept(output int acc);
        int n;
        n = 0;
        acc = -1;
        while (!o_cmd_ready && n < 300) begin
            tick();
            n++;
        end
        if (o_cmd_ready) begin
            acc = cyc;
            tick();
        end else begin
            check("cmd_accept_timeout", 32'd0, 32'd1);
        end
        i_cmd_valid = 0;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int acc);
        present(w, a, d, s);
        wait_accept(acc);
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!o_rsp_valid && n < 300) begin
            tick();
            n++;
        end
        if (!o_rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        tick();
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int acc1, acc2, nb, nr;
        logic [1:0]  hr;
        logic [31:0] hd, a, d;
        for (int i = 0; i < 16; i++) begin
            smem[i] = '0;
            rmem[i] = '0;
        end
        rst = 1; i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = 0; i_cmd_wdata = 0; i_cmd_wstrb = 0;
        repeat (3) tick();
        check("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
        check("rst_valids", 32'({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready}), 32'd0);
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_rsp_resp", 32'(o_rsp_resp), 32'd0);
        check("rst_rsp_rdata", o_rsp_rdata, 32'd0);
        check("rst_addr", o_awaddr | o_araddr, 32'd0);
        check("rst_wdata", o_wdata, 32'd0);
        check("rst_wstrb", 32'(o_wstrb), 32'd0);
        rst = 0;
        tick();
        check("cmd_ready_after_rst", 32'(o_cmd_ready), 32'd1);

        // zero-wait write then back-to-back read
        send(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, acc1);
        check("wr_c1_awvalid", 32'(o_awvalid), 32'd1);
        check("wr_c1_wvalid", 32'(o_wvalid), 32'd1);
        check("wr_c1_awaddr", o_awaddr, 32'h4);
        check("wr_c1_wdata", o_wdata, 32'hDEADBEEF);
        check("wr_c1_wstrb", 32'(o_wstrb), 32'hF);
        tick();
        check("wr_c2_valids", 32'({o_awvalid, o_wvalid}), 32'd0);
        check("wr_c2_bready", 32'(o_bready), 32'd1);
        tick();
        check("wr_c3_rsp_valid", 32'(o_rsp_valid), 32'd1);
        check("wr_c3_resp", 32'(o_rsp_resp), 32'd0);
        check("wr_c3_rdata", o_rsp_rdata, 32'd0);
        send(1'b0, 32'h4, 32'h0, 4'h0, acc2);
        check("throughput", 32'(acc2 - acc1), 32'd4);
        check("rd_c1_arvalid", 32'(o_arvalid), 32'd1);
        check("rd_c1_araddr", o_araddr, 32'h4);
        tick();
        check("rd_c2_rready", 32'(o_rready), 32'd1);
        tick();
        check("rd_c3_rsp_valid", 32'(o_rsp_valid), 32'd1);
        check("rd_c3_rdata", o_rsp_rdata, 32'hDEADBEEF);

        // write / read back
        send(1'b1, 32'h0, 32'h12345678, 4'hF, acc1);
        send(1'b0, 32'h0, 32'h0, 4'h0, acc1);
        wait_rsp();
        check("readback_rdata", o_rsp_rdata, 32'h12345678);
        check("readback_resp", 32'(o_rsp_resp), 32'd0);
        drain();

        // split write: W held off until cycle 4
        w_hold = 3;
        nb = n_b; nr = n_rsp;
        send(1'b1, 32'h8, 32'hA5A50001, 4'h3, acc1);
        check("split_c1_both", 32'({o_awvalid, o_wvalid}), 32'd3);
        tick();
        check("split_c2_awvalid", 32'(o_awvalid), 32'd0);
        check("split_c2_wvalid", 32'(o_wvalid), 32'd1);
        check("split_c2_wdata", o_wdata, 32'hA5A50001);
        tick();
        check("split_c3_wvalid", 32'(o_wvalid), 32'd1);
        tick();
        check("split_c4_wvalid", 32'(o_wvalid), 32'd1);
        tick();
        check("split_c5_wvalid", 32'(o_wvalid), 32'd0);
        check("split_c5_bready", 32'(o_bready), 32'd1);
        drain();
        w_hold = 0;
        check("split_one_b", 32'(n_b - nb), 32'd1);
        check("split_one_rsp", 32'(n_rsp - nr), 32'd1);

        // error codes pass through
        send(1'b0, 32'h80, 32'h0, 4'h0, acc1);
        wait_rsp();
        check("rresp_slverr", 32'(o_rsp_resp), 32'd2);
        send(1'b1, 32'hC0, 32'h55, 4'h1, acc1);
        wait_rsp();
        check("bresp_decerr", 32'(o_rsp_resp), 32'd3);
        drain();

        // response backpressure with a command waiting
        d = 32'h0BADF00D;
        send(1'b1, 32'h10, d, 4'hF, acc1);
        rsp_hold = 5;
        wait_rsp();
        hr = o_rsp_resp; hd = o_rsp_rdata;
        present(1'b0, 32'h10, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
            check("bp_cmd_ready", 32'(o_cmd_ready), 32'd0);
            check("bp_resp", 32'({o_rsp_resp, o_rsp_rdata == hd}), 32'({hr, 1'b1}));
            tick();
        end
        wait_accept(acc1);
        wait_rsp();
        check("bp_next_rdata", o_rsp_rdata, d);
        drain();

        // reset in the middle of a read
        ar_block = 1;
        nr = n_rsp;
        send(1'b0, 32'h10, 32'h0, 4'h0, acc1);
        check("mid_arvalid", 32'(o_arvalid), 32'd1);
        rst = 1;
        #1;
        check("mid_rst_arvalid", 32'(o_arvalid), 32'd0);
        check("mid_rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
        check("mid_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst = 0;
        ar_block = 0;
        tick();
        check("mid_cmd_ready", 32'(o_cmd_ready), 32'd1);
        check("mid_no_rsp", 32'(n_rsp - nr), 32'd0);
        send(1'b0, 32'h10, 32'h0, 4'h0, acc1);
        wait_rsp();
        check("mid_after_rdata", o_rsp_rdata, d);
        drain();
        check("mid_one_rsp", 32'(n_rsp - nr), 32'd1);

        // randomized traffic with random slave waits and response backpressure
        rnd = 1;
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            a[1:0] = 2'b00;
            d = $urandom;
            send(rbit(), a, d, 4'($urandom_range(0, 15)), acc1);
        end
        drain();
        check("cnt_aw_w", 32'(n_aw), 32'(n_w));
        check("cnt_aw_b", 32'(n_aw), 32'(n_b));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

Single-outstanding AXI4-Lite master that converts a simple valid/ready command interface into AXI4-Lite read and write transactions. It returns each transaction's response and read data on a valid/ready response interface. It sits directly upstream of `axi_lite_demo`, driving its AW/W/B/AR/R channels, and replaces bench-driven AXI stimulus with a register-access port usable by cocotb or by other RTL.

## Interface
- ADDR_WIDTH, 32, AXI and command address width
- DATA_WIDTH, 32, AXI and command data width
- STROBE_WIDTH, DATA_WIDTH/8, write strobe width
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid
- i_cmd_write  in  1  1 = write, 0 = read
- i_cmd_addr  in  ADDR_WIDTH  target address
- i_cmd_wdata  in  DATA_WIDTH  write data; ignored for reads
- i_cmd_wstrb  in  STROBE_WIDTH  write strobes; ignored for reads
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  response consumed
- o_rsp_resp  out  2  captured BRESP or RRESP
- o_rsp_rdata  out  DATA_WIDTH  captured RDATA; 0 for writes
- o_awvalid, o_awaddr[ADDR_WIDTH], i_awready: AXI write address channel
- o_wvalid, o_wdata[DATA_WIDTH], o_wstrb[STROBE_WIDTH], i_wready: AXI write data channel
- i_bvalid, i_bresp[2], o_bready: AXI write response channel
- o_arvalid, o_araddr[ADDR_WIDTH], i_arready: AXI read address channel
- i_rvalid, i_rresp[2], i_rdata[DATA_WIDTH], o_rready: AXI read data channel

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: o_cmd_ready = 1, and only in IDLE. On i_cmd_valid, latch addr/wdata/wstrb into registers. Go to WR_REQ if write, else RD_REQ.
- WR_REQ: o_awvalid and o_wvalid are asserted together and tracked independently by done flags aw_done and w_done.
  - Each valid drops the cycle after its own handshake.
  - Once both are done, go to WR_RESP.
  - If both handshakes happen in the same cycle, go to WR_RESP on the next edge.
- WR_RESP: o_bready = 1. On i_bvalid, latch i_bresp, clear rdata, go to RSP.
- RD_REQ: o_arvalid = 1. On i_arready, go to RD_DATA.
- RD_DATA: o_rready = 1. On i_rvalid, latch i_rresp and i_rdata, go to RSP.
- RSP: o_rsp_valid = 1; o_rsp_resp and o_rsp_rdata are held stable. On i_rsp_ready, go to IDLE.
- AXI valids, once raised, never drop before their handshake. Address, data and strobe outputs stay stable while the valid is high.
- One transaction outstanding at a time; no command reordering.
- Response codes pass through unmodified. SLVERR and DECERR are not treated specially.
- Reset at any point forces IDLE and aborts the transaction; any pending response is discarded.

## Timing
- Reset values:
  - all AXI valids/readies 0; o_cmd_ready 0 while rst high, 1 the first cycle after release
  - o_rsp_valid 0; o_rsp_resp 0; o_rsp_rdata 0
  - o_awaddr, o_araddr, o_wdata, o_wstrb 0
- All outputs are registered or decoded from the state register. No combinational path from any input to any output.
- Write with a zero-wait slave:
  - cycle 0: command accepted
  - cycle 1: AW and W handshake
  - cycle 2: o_bready high (B handshake if the slave has i_bvalid up)
  - cycle 3: o_rsp_valid
- Read with a zero-wait slave:
  - cycle 0: command accepted
  - cycle 1: AR handshake
  - cycle 2: R handshake
  - cycle 3: o_rsp_valid
- Throughput: the next command is accepted the cycle after the response handshake, giving a minimum of 4 cycles per transaction.
- i_bvalid or i_rvalid arriving before the master's ready is high waits. The handshake completes on the first cycle in which both are high.

## Test plan
- Write, zero-wait slave: cmd write addr 0x4, data 0xDEADBEEF, wstrb 0xF -> AW/W on cycle 1 with matching values; rsp_valid on cycle 3; resp 0; rdata 0.
- Split write: i_awready at cycle 1, i_wready delayed to cycle 4 -> o_awvalid drops at cycle 2; o_wvalid held with stable data until cycle 4; exactly one B accepted; exactly one response.
- Write/read back against axi_lite_demo: write 0x12345678 to addr 0, read addr 0 -> read response rdata 0x12345678, resp 0.
- Error propagation: slave returns RRESP 2'b10 -> o_rsp_resp 2'b10. Then BRESP 2'b11 on a write -> o_rsp_resp 2'b11.
- Response backpressure: hold i_rsp_ready low 5 cycles -> rsp_valid, resp and rdata stable; o_cmd_ready stays 0; i_cmd_valid ignored until the handshake.
- Reset mid-read: assert rst while o_arvalid is high -> o_arvalid falls in the same cycle with no clock edge needed; no response is issued. After release, a new read completes normally.
